// File: rtl/ram_op_enum.sv
// Shared RAM-operation encodings and decode helpers for the hxd32 MEM stage.
package ram_op_enum;

    typedef enum logic [2:0] {
        DRAM_RD_B  = 3'b000,
        DRAM_RD_H  = 3'b001,
        DRAM_RD_W  = 3'b010,
        DRAM_RD_BU = 3'b100,
        DRAM_RD_HU = 3'b101
    } dram_rd_sel_e;

    function automatic logic rd_sel_legal(input logic [2:0] sel);
        case (sel)
            DRAM_RD_B, DRAM_RD_H, DRAM_RD_W, DRAM_RD_BU, DRAM_RD_HU: rd_sel_legal = 1'b1;
            default:                                                 rd_sel_legal = 1'b0;
        endcase
    endfunction

    // A load crosses a word when its last byte lands in the next word.
    function automatic logic rd_crosses(input logic [2:0] sel, input logic [1:0] off);
        case (sel)
            DRAM_RD_H, DRAM_RD_HU: rd_crosses = (off == 2'd3);
            DRAM_RD_W:             rd_crosses = (off != 2'd0);
            default:               rd_crosses = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Byte-lane extraction and sign/zero extension of a load from a {hi,lo} word pair.
module load_extract
    import ram_op_enum::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] i_pair,
    input  logic [1:0]        i_offset,
    input  logic [2:0]        i_sel,
    output logic [XLEN-1:0]   o_result
);

    logic [XLEN-1:0] w_m;

    assign w_m = XLEN'(i_pair >> {i_offset, 3'b000});

    always_comb begin
        o_result = '0;
        case (i_sel)
            DRAM_RD_B:  o_result = {{(XLEN-8){w_m[7]}}, w_m[7:0]};
            DRAM_RD_BU: o_result = {{(XLEN-8){1'b0}}, w_m[7:0]};
            DRAM_RD_H:  o_result = {{(XLEN-16){w_m[15]}}, w_m[15:0]};
            DRAM_RD_HU: o_result = {{(XLEN-16){1'b0}}, w_m[15:0]};
            DRAM_RD_W:  o_result = w_m;
            default:    o_result = '0;
        endcase
    end

endmodule

// File: rtl/dram_rd_unit.sv
// MEM-stage load path: word reads over req/ack, split/merge of word-crossing loads,
// extended result returned with a one-cycle valid pulse.
module dram_rd_unit
    import ram_op_enum::*;
#(
    parameter int XLEN        = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            dram_rd_en_i,
    input  logic [2:0]      dram_rd_sel_i,
    input  logic [XLEN-1:0] dram_rd_addr_i,
    output logic            dram_rd_busy_o,
    output logic            dram_rd_valid_o,
    output logic            dram_rd_err_o,
    output logic [XLEN-1:0] dram_rd_data_o,
    output logic            dram_req_o,
    output logic [XLEN-3:0] dram_addr_o,
    input  logic            dram_ack_i,
    input  logic [XLEN-1:0] dram_data_i
);

    if (XLEN != 32) begin : g_xlen_chk
        $error("dram_rd_unit: only XLEN=32 is supported");
    end

    typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, RESP} state_e;

    state_e          r_state;
    logic [XLEN-1:0] r_addr;
    logic [2:0]      r_sel;
    logic            r_cross;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_hi;
    logic            r_busy;
    logic            r_valid;
    logic            r_err;
    logic [XLEN-1:0] r_data;
    logic            r_req;
    logic [XLEN-3:0] r_waddr;

    logic            w_accept;
    logic            w_cross_in;
    logic            w_bad;
    logic [XLEN-1:0] w_lo;
    logic [XLEN-1:0] w_hi;
    logic [XLEN-1:0] w_result;

    assign w_accept   = dram_rd_en_i && (r_state == IDLE || r_state == RESP);
    assign w_cross_in = rd_crosses(dram_rd_sel_i, dram_rd_addr_i[1:0]);
    assign w_bad      = !rd_sel_legal(dram_rd_sel_i) || (w_cross_in && !MISALIGN_EN);

    // Feed the acked word straight into the extractor so the result registers on RESP entry.
    assign w_lo = (r_state == RD_LO) ? dram_data_i : r_lo;
    assign w_hi = (r_state == RD_HI) ? dram_data_i : r_hi;

    load_extract #(.XLEN(XLEN)) u_extract (
        .i_pair   ({w_hi, w_lo}),
        .i_offset (r_addr[1:0]),
        .i_sel    (r_sel),
        .o_result (w_result)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_sel   <= '0;
            r_cross <= 1'b0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
            r_req   <= 1'b0;
            r_waddr <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE, RESP: begin
                    if (w_accept) begin
                        r_addr  <= dram_rd_addr_i;
                        r_sel   <= dram_rd_sel_i;
                        r_cross <= w_cross_in;
                        r_lo    <= '0;
                        r_hi    <= '0;
                        if (w_bad) begin
                            r_state <= RESP;
                            r_valid <= 1'b1;
                            r_err   <= 1'b1;
                            r_data  <= '0;
                        end else begin
                            r_state <= RD_LO;
                            r_req   <= 1'b1;
                            r_busy  <= 1'b1;
                            r_waddr <= dram_rd_addr_i[XLEN-1:2];
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RD_LO: begin
                    if (dram_ack_i) begin
                        r_lo <= dram_data_i;
                        if (r_cross) begin
                            r_state <= RD_HI;
                            r_waddr <= r_waddr + 1'b1;
                        end else begin
                            r_state <= RESP;
                            r_req   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b1;
                            r_data  <= w_result;
                        end
                    end
                end
                RD_HI: begin
                    if (dram_ack_i) begin
                        r_hi    <= dram_data_i;
                        r_state <= RESP;
                        r_req   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                        r_data  <= w_result;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dram_rd_busy_o  = r_busy;
    assign dram_rd_valid_o = r_valid;
    assign dram_rd_err_o   = r_err;
    assign dram_rd_data_o  = r_data;
    assign dram_req_o      = r_req;
    assign dram_addr_o     = r_waddr;

endmodule

// File: tb/tb_dram_rd_unit.sv
// Directed bench for dram_rd_unit: a RAM responder with programmable ack delay plus
// a second instance built with word-crossing loads disabled.
module tb_dram_rd_unit;

    logic        clk, rst_n;
    logic        en, ack;
    logic [2:0]  sel;
    logic [31:0] addr, ram_data;
    logic        busy, valid, err, req;
    logic [31:0] data_o;
    logic [29:0] waddr;

    logic        en0, ack0;
    logic [2:0]  sel0;
    logic [31:0] addr0, ram_data0;
    logic        busy0, valid0, err0, req0;
    logic [31:0] data0_o;
    logic [29:0] waddr0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem [256];
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    int          unstable  = 0;
    int          req_cycles0 = 0;
    logic        pend = 1'b0;
    logic [29:0] pend_addr = '0;
    logic [29:0] ack_q[$];

    dram_rd_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .dram_rd_en_i(en), .dram_rd_sel_i(sel), .dram_rd_addr_i(addr),
        .dram_rd_busy_o(busy), .dram_rd_valid_o(valid), .dram_rd_err_o(err),
        .dram_rd_data_o(data_o), .dram_req_o(req), .dram_addr_o(waddr),
        .dram_ack_i(ack), .dram_data_i(ram_data)
    );

    dram_rd_unit #(.XLEN(32), .MISALIGN_EN(1'b0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n),
        .dram_rd_en_i(en0), .dram_rd_sel_i(sel0), .dram_rd_addr_i(addr0),
        .dram_rd_busy_o(busy0), .dram_rd_valid_o(valid0), .dram_rd_err_o(err0),
        .dram_rd_data_o(data0_o), .dram_req_o(req0), .dram_addr_o(waddr0),
        .dram_ack_i(ack0), .dram_data_i(ram_data0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM responder: acks after ack_delay request cycles, logs acked word addresses.
    initial begin
        ack = 1'b0;
        ram_data = '0;
        forever begin
            @(negedge clk);
            if (req0) req_cycles0++;
            if (req && pend && waddr != pend_addr) unstable++;
            if (req && wait_cnt >= ack_delay) begin
                ack = 1'b1;
                ram_data = mem[waddr[7:0]];
                ack_q.push_back(waddr);
                wait_cnt = 0;
                pend = 1'b0;
            end else begin
                ack = 1'b0;
                ram_data = 32'hBAD0BAD0;
                if (req) wait_cnt++; else wait_cnt = 0;
                pend = req;
                pend_addr = waddr;
            end
        end
    end

    task automatic run_load(input logic [31:0] a, input logic [2:0] s,
                            output logic [31:0] d, output logic e, output int lat,
                            output int busy_lo, output logic v_after);
        @(negedge clk);
        en = 1'b1; addr = a; sel = s;
        @(negedge clk);
        en = 1'b0;
        lat = -1;
        busy_lo = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid) begin
                lat = i;
                break;
            end
            if (!busy) busy_lo++;
            @(negedge clk);
        end
        d = data_o;
        e = err;
        @(negedge clk);
        v_after = valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; sel = '0; addr = '0;
        en0 = 1'b0; sel0 = '0; addr0 = '0; ack0 = 1'b0; ram_data0 = '0;
        #12;
        n_chk++;
        if ({busy, valid, err, req, data_o, waddr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b valid=%b err=%b req=%b data=%h addr=%h exp all 0",
                     busy, valid, err, req, data_o, waddr);
        end
        n_chk++;
        if ({busy0, valid0, err0, req0, data0_o, waddr0} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_m0 got valid=%b err=%b req=%b exp 0", valid0, err0, req0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (valid !== 1'b0 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset got valid=%b req=%b exp 0 0", valid, req);
        end
    endtask

    task automatic test_lw_aligned();
        logic [31:0] d; logic e, va; int lat, bl;
        mem[8'h40] = 32'hDEADBEEF;
        ack_delay = 0; ack_q.delete();
        run_load(32'h100, 3'b010, d, e, lat, bl, va);
        n_chk++;
        if (d !== 32'hDEADBEEF || e !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_aligned_data got %h err=%b exp deadbeef err=0", d, e);
        end
        n_chk++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL lw_aligned_latency got %0d exp 1", lat);
        end
        n_chk++;
        if (ack_q.size() != 1 || ack_q[0] !== 30'h40) begin
            n_fail++;
            $display("FAIL lw_aligned_reqs got n=%0d exp one req at 0x40", ack_q.size());
        end
        n_chk++;
        if (va !== 1'b0 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_aligned_pulse got valid_next=%b req=%b exp 0 0", va, req);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] d; logic e, va; int lat, bl;
        logic [31:0] a_tab [4]   = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [2:0]  s_tab [4]   = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] exp_tab [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
        mem[8'h40] = 32'h80FF1234;
        ack_delay = 0;
        for (int i = 0; i < 4; i++) begin
            run_load(a_tab[i], s_tab[i], d, e, lat, bl, va);
            n_chk++;
            if (d !== exp_tab[i] || e !== 1'b0 || lat !== 1) begin
                n_fail++;
                $display("FAIL byte_half_%0d got %h err=%b lat=%0d exp %h err=0 lat=1",
                         i, d, e, lat, exp_tab[i]);
            end
        end
    endtask

    task automatic test_crossing();
        logic [31:0] d; logic e, va; int lat, bl;
        mem[8'h40] = 32'h44332211;
        mem[8'h41] = 32'h88776655;
        ack_delay = 0; ack_q.delete();
        run_load(32'h101, 3'b010, d, e, lat, bl, va);
        n_chk++;
        if (d !== 32'h55443322 || e !== 1'b0 || lat !== 2) begin
            n_fail++;
            $display("FAIL lw_cross got %h err=%b lat=%0d exp 55443322 err=0 lat=2", d, e, lat);
        end
        n_chk++;
        if (ack_q.size() != 2 || ack_q[0] !== 30'h40 || ack_q[1] !== 30'h41) begin
            n_fail++;
            $display("FAIL lw_cross_reqs got n=%0d exp reqs 0x40 then 0x41", ack_q.size());
        end
        run_load(32'h103, 3'b001, d, e, lat, bl, va);
        n_chk++;
        if (d !== 32'h00005544 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL lh_cross got %h err=%b exp 00005544 err=0", d, e);
        end
        // Last word of the address space wraps to word 0.
        mem[8'hFF] = 32'hAABBCCDD;
        mem[8'h00] = 32'h11223344;
        ack_q.delete();
        run_load(32'hFFFFFFFF, 3'b010, d, e, lat, bl, va);
        n_chk++;
        if (d !== 32'h223344AA || ack_q.size() != 2 || ack_q[0] !== 30'h3FFFFFFF || ack_q[1] !== 30'h0) begin
            n_fail++;
            $display("FAIL lw_wrap got %h nreq=%0d exp 223344aa reqs 3fffffff then 0", d, ack_q.size());
        end
    endtask

    task automatic test_misalign_off();
        @(negedge clk);
        en0 = 1'b1; addr0 = 32'h101; sel0 = 3'b010;
        @(negedge clk);
        en0 = 1'b0;
        n_chk++;
        if (valid0 !== 1'b1 || err0 !== 1'b1 || data0_o !== 32'h0) begin
            n_fail++;
            $display("FAIL misalign_off_resp got valid=%b err=%b data=%h exp 1 1 0", valid0, err0, data0_o);
        end
        @(negedge clk);
        n_chk++;
        if (valid0 !== 1'b0 || req_cycles0 != 0) begin
            n_fail++;
            $display("FAIL misalign_off_noreq got valid=%b req_cycles=%0d exp 0 0", valid0, req_cycles0);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] d; logic e, va; int lat, bl;
        mem[8'h40] = 32'h44332211;
        mem[8'h41] = 32'h88776655;
        ack_delay = 3; unstable = 0; ack_q.delete();
        run_load(32'h101, 3'b010, d, e, lat, bl, va);
        n_chk++;
        if (d !== 32'h55443322 || lat !== 8) begin
            n_fail++;
            $display("FAIL wait_data got %h lat=%0d exp 55443322 lat=8", d, lat);
        end
        n_chk++;
        if (bl != 0 || unstable != 0 || va !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_handshake got busy_low=%0d addr_changes=%0d valid_next=%b exp 0 0 0",
                     bl, unstable, va);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        bit hit = 0;
        ack_delay = 3;
        @(negedge clk);
        en = 1'b1; addr = 32'h101; sel = 3'b010;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req && waddr == 30'h41) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reset_mid_reach got no RD_HI request exp req at 0x41");
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (req !== 1'b0 || busy !== 1'b0 || waddr !== 30'h0) begin
            n_fail++;
            $display("FAIL reset_mid_drop got req=%b busy=%b addr=%h exp 0 0 0", req, busy, waddr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid || req) seen++;
        end
        n_chk++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_mid_novalid got %0d active cycles exp 0", seen);
        end
        ack_delay = 0;
    endtask

    task automatic test_back_to_back();
        mem[8'h40] = 32'hDEADBEEF;
        ack_delay = 0; ack_q.delete();
        @(negedge clk);
        en = 1'b1; addr = 32'h100; sel = 3'b011;
        @(negedge clk);
        n_chk++;
        if (valid !== 1'b1 || err !== 1'b1 || data_o !== 32'h0 || req !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_sel got valid=%b err=%b data=%h req=%b exp 1 1 0 0", valid, err, data_o, req);
        end
        sel = 3'b010;
        @(negedge clk);
        en = 1'b0;
        n_chk++;
        if (req !== 1'b1 || busy !== 1'b1 || waddr !== 30'h40 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_bubble got req=%b busy=%b addr=%h valid=%b exp 1 1 40 0",
                     req, busy, waddr, valid);
        end
        @(negedge clk);
        n_chk++;
        if (valid !== 1'b1 || err !== 1'b0 || data_o !== 32'hDEADBEEF || ack_q.size() != 1) begin
            n_fail++;
            $display("FAIL b2b_result got valid=%b err=%b data=%h nreq=%0d exp 1 0 deadbeef 1",
                     valid, err, data_o, ack_q.size());
        end
        @(negedge clk);
        n_chk++;
        if (valid !== 1'b0 || data_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL b2b_hold got valid=%b data=%h exp 0 deadbeef", valid, data_o);
        end
    endtask

    initial begin
        test_reset();
        test_lw_aligned();
        test_byte_half();
        test_crossing();
        test_misalign_off();
        test_wait_states();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_rd_unit.md
Name: dram_rd_unit

Overview:
Load-side counterpart of the MEM-stage store path in the hxd32 core. It accepts one load request per transaction: byte address plus RISC-V load funct3. It issues word reads to the data RAM over a req/ack handshake. It returns the extracted, sign- or zero-extended result with a one-cycle valid pulse. A load that crosses a word boundary is split into two word reads and the halves are merged.

Parameters:
XLEN, 32, data/address width; only 32 is supported (elaboration-time assertion).
MISALIGN_EN, 1, 1 = split word-crossing loads into two reads; 0 = flag them as errors with no read.

Ports:
clk_i  in  1  core clock
rst_n_i  in  1  reset; asynchronous, active-low
dram_rd_en_i  in  1  load request strobe, one cycle per load
dram_rd_sel_i  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
dram_rd_addr_i  in  XLEN  byte address
dram_rd_busy_o  out  1  read in progress; upstream holds the pipeline
dram_rd_valid_o  out  1  result valid, one-cycle pulse
dram_rd_err_o  out  1  illegal sel or disallowed misalignment, pulses with valid
dram_rd_data_o  out  XLEN  load result
dram_req_o  out  1  RAM read request
dram_addr_o  out  XLEN-2  RAM word address
dram_ack_i  in  1  RAM read acknowledge; data valid in the same cycle
dram_data_i  in  XLEN  RAM read data

Behaviour:
- Reset: state IDLE; all outputs 0; latched addr, sel, lo and hi buffers cleared. Reset mid-transaction drops dram_req_o immediately (async). No valid is produced for the aborted load.
- FSM states: IDLE, RD_LO, RD_HI, RESP.
- Acceptance: dram_rd_en_i is sampled only in IDLE or RESP, which allows back-to-back loads. In RD_LO/RD_HI it is ignored. On accept, latch addr and sel.
- Accept with legal sel and no error: go to RD_LO.
- Accept with illegal sel, or a crossing load with MISALIGN_EN=0: go to RESP with err set and data 0. No RAM request is issued.
- Crossing condition: LH/LHU with offset 3; LW with offset != 0. Offset = addr[1:0].
- RD_LO: dram_req_o=1, dram_addr_o=addr[XLEN-1:2], held stable until ack. On ack, capture lo = dram_data_i; go to RD_HI if crossing, else RESP.
- RD_HI: dram_req_o=1, dram_addr_o=addr[XLEN-1:2]+1, wrapping modulo 2^(XLEN-2). On ack, capture hi and go to RESP.
- RESP: dram_rd_valid_o=1 and dram_rd_err_o per latched flag for exactly one cycle. Next state is RD_LO on a new accept, otherwise IDLE.
- dram_rd_busy_o is registered and equals (state is RD_LO or RD_HI).
- Data path: m = ({hi,lo} >> 8*offset)[XLEN-1:0], with hi = 0 when not crossing.
  - LB: sign-extend m[7:0]. LBU: zero-extend m[7:0].
  - LH: sign-extend m[15:0]. LHU: zero-extend m[15:0].
  - LW: m.
- dram_rd_data_o is registered on entry to RESP and holds its value until the next RESP.
- Acks outside RD_LO/RD_HI are ignored. dram_req_o is never asserted in IDLE or RESP.
- Latency with zero-wait ack: accept at cycle T, RD_LO at T+1, valid at T+2. Each extra read or wait cycle adds one cycle.

Decomposition:
- Package ram_op_enum gains a dram_rd_sel enum: DRAM_RD_B=3'b000, DRAM_RD_H=3'b001, DRAM_RD_W=3'b010, DRAM_RD_BU=3'b100, DRAM_RD_HU=3'b101.
- The FSM state enum stays local to the module.
- One combinational sub-module, load_extract (inputs {hi,lo}, offset, sel; output result), shared with future bench checkers.

Test Plan:
- LW addr 0x100, ack same cycle, data 0xDEADBEEF -> one req at word addr 0x40; valid at T+2 with 0xDEADBEEF; err 0.
- LB addr 0x103, word 0x80FF1234 -> 0xFFFFFF80; LBU at same addr -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF; LHU addr 0x102 -> 0x000080FF.
- LW addr 0x101, word 0x40 = 0x44332211, word 0x41 = 0x88776655 -> reqs to 0x40 then 0x41; result 0x55443322.
  - LH addr 0x103 on the same words -> 0x00005544.
  - With MISALIGN_EN=0, the LW -> no req; valid and err set; data 0.
- ack delayed 3 cycles in both RD_LO and RD_HI -> req and addr held stable, busy high throughout, single valid pulse.
  - rst_n_i asserted during RD_HI -> req drops that cycle; no valid after reset release.
- sel 3'b011 -> no req; valid and err at T+1; data 0.
  - New LW accepted in that RESP cycle -> RD_LO the next cycle, no idle bubble.
